uart_debug_ctrl: RTL

UART-driven run-control sequencer for the FemtoRV32 pipelined datapath. It consumes command bytes from the UART byte receiver and produces the datapath's reset, a clock-enable (free-run, single-step, N-step), and the LED/SSD display-select fields. It replaces the direct mapping of received bits onto datapath control pins with a command protocol, and sits between the UART receiver and `Full_dataPath` in the top level.

---
 rtl/uart_dbg_pkg.sv | 36 +++
 rtl/ctrl_down_counter.sv | 29 ++
 rtl/uart_debug_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART run-control sequencer: opcodes, state encoding
// and widths.
package uart_dbg_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned STEP_W     = 8;
    localparam int unsigned LED_W      = 2;
    localparam int unsigned SSD_W      = 4;
    localparam int unsigned STEP_CNT_W = 16;

    localparam logic [BYTE_W-1:0] OP_RESET = 8'h52;
    localparam logic [BYTE_W-1:0] OP_RUN   = 8'h47;
    localparam logic [BYTE_W-1:0] OP_HALT  = 8'h48;
    localparam logic [BYTE_W-1:0] OP_STEP  = 8'h53;
    localparam logic [BYTE_W-1:0] OP_NSTEP = 8'h4E;
    localparam logic [BYTE_W-1:0] OP_LED   = 8'h4C;
    localparam logic [BYTE_W-1:0] OP_SSD   = 8'h44;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_IDLE       = 2'd1,
        ST_ARG_WAIT   = 2'd2,
        ST_STEPPING   = 2'd3
    } state_e;

    typedef struct packed {
        logic [LED_W-1:0] led;
        logic [SSD_W-1:0] ssd;
    } disp_sel_t;

    // Opcodes that are followed by an argument byte.
    function automatic logic is_arg_op(input logic [BYTE_W-1:0] b);
        return (b == OP_NSTEP) || (b == OP_LED) || (b == OP_SSD);
    endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and the count
// saturates at zero.
module ctrl_down_counter #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/uart_debug_ctrl.sv
// UART command sequencer for datapath run control: reset, free-run, single and
// N-step clock enables, and display selects. Counters hold "remaining - 1".
module uart_debug_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned ARG_TIMEOUT = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  cpu_rst,
    output logic                  cpu_ce,
    output logic [LED_W-1:0]      led_sel,
    output logic [SSD_W-1:0]      ssd_sel,
    output logic                  running,
    output logic                  busy,
    output logic                  cmd_err,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(ARG_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(ARG_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [BYTE_W-1:0]       op_q, op_d;
    disp_sel_t               sel_q, sel_d;
    logic                    running_q, running_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    cpu_ce_q, cpu_ce_d;
    logic                    busy_q, busy_d;
    logic                    cmd_err_q, cmd_err_d;
    logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;

    logic                    hold_load, hold_dec, hold_zero;
    logic                    step_load, step_dec, step_zero;
    logic [STEP_W-1:0]       step_val;
    logic                    tmo_load, tmo_dec, tmo_zero;

    ctrl_down_counter #(.W(HOLD_W), .RST_VAL(HOLD_LOAD)) u_hold_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hold_load),
        .load_val_i (HOLD_LOAD),
        .dec_i      (hold_dec),
        .zero_c     (hold_zero)
    );

    ctrl_down_counter #(.W(STEP_W), .RST_VAL('0)) u_step_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (step_load),
        .load_val_i (step_val),
        .dec_i      (step_dec),
        .zero_c     (step_zero)
    );

    ctrl_down_counter #(.W(TMO_W), .RST_VAL('0)) u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .dec_i      (tmo_dec),
        .zero_c     (tmo_zero)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET_HOLD;
            op_q       <= '0;
            sel_q      <= '0;
            running_q  <= 1'b0;
            cpu_rst_q  <= 1'b1;
            cpu_ce_q   <= 1'b0;
            busy_q     <= 1'b1;
            cmd_err_q  <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sel_q      <= sel_d;
            running_q  <= running_d;
            cpu_rst_q  <= cpu_rst_d;
            cpu_ce_q   <= cpu_ce_d;
            busy_q     <= busy_d;
            cmd_err_q  <= cmd_err_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Command decode, next state and next-cycle outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sel_d     = sel_q;
        running_d = running_q;
        cmd_err_d = 1'b0;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        step_load = 1'b0;
        step_dec  = 1'b0;
        step_val  = '0;
        tmo_load  = 1'b0;
        tmo_dec   = 1'b0;

        unique case (state_q)
            ST_RESET_HOLD: begin
                if (rx_valid && (rx_data == OP_RESET)) begin
                    hold_load = 1'b1;
                end else begin
                    cmd_err_d = rx_valid;
                    if (hold_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_dec = 1'b1;
                    end
                end
            end

            ST_IDLE: begin
                if (rx_valid) begin
                    if (is_arg_op(rx_data)) begin
                        op_d     = rx_data;
                        tmo_load = 1'b1;
                        state_d  = ST_ARG_WAIT;
                    end else begin
                        case (rx_data)
                            OP_RESET: begin
                                running_d = 1'b0;
                                hold_load = 1'b1;
                                state_d   = ST_RESET_HOLD;
                            end
                            OP_RUN:  running_d = 1'b1;
                            OP_HALT: running_d = 1'b0;
                            OP_STEP: begin
                                running_d = 1'b0;
                                step_val  = STEP_W'(0);
                                step_load = 1'b1;
                                state_d   = ST_STEPPING;
                            end
                            default: cmd_err_d = 1'b1;
                        endcase
                    end
                end
            end

            ST_ARG_WAIT: begin
                if (rx_valid) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_LED: sel_d.led = rx_data[LED_W-1:0];
                        OP_SSD: sel_d.ssd = rx_data[SSD_W-1:0];
                        default: begin
                            if (rx_data == '0) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                running_d = 1'b0;
                                step_val  = STEP_W'(rx_data - BYTE_W'(1));
                                step_load = 1'b1;
                                state_d   = ST_STEPPING;
                            end
                        end
                    endcase
                end else if (tmo_zero) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_dec = 1'b1;
                end
            end

            ST_STEPPING: begin
                if (rx_valid && (rx_data == OP_HALT)) begin
                    state_d = ST_IDLE;
                end else if (rx_valid && (rx_data == OP_RESET)) begin
                    hold_load = 1'b1;
                    state_d   = ST_RESET_HOLD;
                end else begin
                    cmd_err_d = rx_valid;
                    if (step_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        step_dec = 1'b1;
                    end
                end
            end

            default: state_d = ST_RESET_HOLD;
        endcase

        cpu_rst_d = (state_d == ST_RESET_HOLD);
        busy_d    = (state_d != ST_IDLE);
        case (state_d)
            ST_STEPPING:          cpu_ce_d = 1'b1;
            ST_IDLE, ST_ARG_WAIT: cpu_ce_d = running_d;
            default:              cpu_ce_d = 1'b0;
        endcase
        // Count cycles the datapath was enabled; entering reset clears it.
        step_cnt_d = (state_d == ST_RESET_HOLD) ? '0
                   : step_cnt_q + STEP_CNT_W'(cpu_ce_q);
    end

    assign cpu_rst  = cpu_rst_q;
    assign cpu_ce   = cpu_ce_q;
    assign led_sel  = sel_q.led;
    assign ssd_sel  = sel_q.ssd;
    assign running  = running_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;
    assign step_cnt = step_cnt_q;

endmodule
